// File: rtl/rx_timer_pkg.sv
// rx_timer_pkg: shared state encoding, stuff limit and width helpers for rx_bit_timer
package rx_timer_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, STUFF} rx_state_t;
    localparam int STUFF_LIMIT = 6;
    function automatic int phase_w(input int clks_per_bit);
        return $clog2(clks_per_bit);
    endfunction
    function automatic int bit_w(input int bits_per_byte);
        return $clog2(bits_per_byte);
    endfunction
endpackage

// File: rtl/rx_bit_timer_if.sv
// rx_bit_timer_if: edge/receive inputs and sample/byte strobes of rx_bit_timer
interface rx_bit_timer_if #(parameter int BIT_W = 3);
    logic d_edge, rcving, d_orig, shift_enable, byte_received, stuff_err;
    logic [BIT_W-1:0] bit_count;
    modport master (output d_edge, rcving, d_orig, input shift_enable, byte_received, bit_count, stuff_err);
    modport slave (input d_edge, rcving, d_orig, output shift_enable, byte_received, bit_count, stuff_err);
endinterface

// File: rtl/rx_phase_gen.sv
// rx_phase_gen: bit phase counter resynchronised by data edges, with sample point strobe
module rx_phase_gen
    import rx_timer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PT = 3,
    localparam int PW = phase_w(CLKS_PER_BIT)
) (
    input logic clk,
    input logic n_rst,
    input logic clr,
    input logic en,
    input logic d_edge,
    output logic [PW-1:0] phase,
    output logic sample_pt
);
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) phase <= '0;
        else if (clr) phase <= '0;
        else if (en) phase <= (d_edge || phase == PW'(CLKS_PER_BIT - 1)) ? '0 : phase + PW'(1);
    assign sample_pt = phase == PW'(SAMPLE_PT);
endmodule

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: bit sample strobe and byte timing for the USB receiver; bit-stuff removal under RX_BIT_STUFF_EN
module rx_bit_timer
    import rx_timer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PT = 3,
    parameter int BITS_PER_BYTE = 8
) (
    input logic clk,
    input logic n_rst,
    rx_bit_timer_if.slave bus
);
    localparam int PW = phase_w(CLKS_PER_BIT);
    localparam int BW = bit_w(BITS_PER_BYTE);
    rx_state_t state, next_state;
    logic [PW-1:0] phase;
    logic [BW-1:0] bit_count;
    logic sample_pt, shift_en, last_bit, byte_rcvd;
    rx_phase_gen #(.CLKS_PER_BIT(CLKS_PER_BIT), .SAMPLE_PT(SAMPLE_PT)) u_phase (
        .clk(clk),
        .n_rst(n_rst),
        .clr(!bus.rcving),
        .en(state != IDLE),
        .d_edge(bus.d_edge),
        .phase(phase),
        .sample_pt(sample_pt)
    );
    // rcving low is a synchronous clear, so no strobe may escape in that cycle
    assign shift_en = bus.rcving && state == ACTIVE && sample_pt;
    assign last_bit = bit_count == BW'(BITS_PER_BYTE - 1);
`ifdef RX_BIT_STUFF_EN
    logic [2:0] ones;
    logic stuff_pt, stuff_err;
    assign stuff_pt = bus.rcving && state == STUFF && sample_pt;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            ones <= '0;
            stuff_err <= 1'b0;
        end else begin
            stuff_err <= stuff_pt && bus.d_orig;
            if (!bus.rcving || stuff_pt) ones <= '0;
            else if (shift_en) ones <= bus.d_orig ? ones + 3'd1 : '0;
        end
    assign bus.stuff_err = stuff_err;
`else
    logic unused_d_orig;
    assign unused_d_orig = bus.d_orig;
    assign bus.stuff_err = 1'b0;
`endif
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) state <= IDLE;
        else state <= next_state;
    always_comb begin
        next_state = state;
        if (!bus.rcving) next_state = IDLE;
        else if (state == IDLE) next_state = ACTIVE;
`ifdef RX_BIT_STUFF_EN
        else if (shift_en && bus.d_orig && ones == 3'(STUFF_LIMIT - 1)) next_state = STUFF;
        else if (stuff_pt) next_state = ACTIVE;
`endif
    end
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            bit_count <= '0;
            byte_rcvd <= 1'b0;
        end else begin
            byte_rcvd <= shift_en && last_bit;
            if (!bus.rcving) bit_count <= '0;
            else if (shift_en) bit_count <= last_bit ? '0 : bit_count + BW'(1);
        end
    assign bus.shift_enable = shift_en;
    assign bus.byte_received = byte_rcvd;
    assign bus.bit_count = bit_count;
    sample_at_phase: assert property (@(posedge clk) disable iff (!n_rst) shift_en |-> phase == PW'(SAMPLE_PT));
endmodule

// File: tb/tb_rx_bit_timer.sv
// tb_rx_bit_timer: directed checks of rx_bit_timer timing, resync, drop, reset and stuffing
module tb_rx_bit_timer;
    import rx_timer_pkg::*;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    rx_bit_timer_if #(.BIT_W(bit_w(8))) a ();
    rx_bit_timer_if #(.BIT_W(bit_w(5))) b ();
    rx_bit_timer dut_a (.clk(clk), .n_rst(n_rst), .bus(a));
    rx_bit_timer #(.CLKS_PER_BIT(4), .SAMPLE_PT(1), .BITS_PER_BYTE(5)) dut_b (.clk(clk), .n_rst(n_rst), .bus(b));

    task automatic win(input logic e, input logic r, input logic d);
        @(negedge clk);
        a.d_edge = e;
        a.rcving = r;
        a.d_orig = d;
        #1;
    endtask

    task automatic start_a();
        win(0, 0, 0);
        win(0, 0, 0);
        win(0, 1, 0);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        a.d_edge = 0; a.rcving = 0; a.d_orig = 0;
        b.d_edge = 0; b.rcving = 0; b.d_orig = 0;
        #1;
        checks += 2;
        if ({a.shift_enable, a.byte_received, a.stuff_err, a.bit_count} !== 6'd0) begin
            errors++;
            $display("FAIL reset_a se/br/se_err/bc got %b exp 000000", {a.shift_enable, a.byte_received, a.stuff_err, a.bit_count});
        end
        if ({b.shift_enable, b.byte_received, b.stuff_err, b.bit_count} !== 6'd0) begin
            errors++;
            $display("FAIL reset_b se/br/se_err/bc got %b exp 000000", {b.shift_enable, b.byte_received, b.stuff_err, b.bit_count});
        end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_edges();
        start_a();
        for (int k = 0; k < 64; k++) begin
            win(k % 8 == 0 && k <= 56, 1, 0);
            checks += 2;
            if (a.shift_enable !== (k % 8 == 4)) begin
                errors++;
                $display("FAIL edges shift_enable k=%0d got %b exp %b", k, a.shift_enable, k % 8 == 4);
            end
            if (a.byte_received !== (k == 61)) begin
                errors++;
                $display("FAIL edges byte_received k=%0d got %b exp %b", k, a.byte_received, k == 61);
            end
            if (k == 59 || k == 63) begin
                checks++;
                if (a.bit_count !== (k == 59 ? 3'd7 : 3'd0)) begin
                    errors++;
                    $display("FAIL edges bit_count k=%0d got %0d exp %0d", k, a.bit_count, k == 59 ? 7 : 0);
                end
            end
        end
    endtask

    task automatic test_jitter();
        logic exp_se;
        start_a();
        for (int k = 0; k < 28; k++) begin
            win(k == 0 || k == 10 || k == 22, 1, 0);
            exp_se = k == 4 || k == 14 || k == 22 || k == 26;
            checks++;
            if (a.shift_enable !== exp_se) begin
                errors++;
                $display("FAIL jitter shift_enable k=%0d got %b exp %b", k, a.shift_enable, exp_se);
            end
        end
        checks++;
        if (a.bit_count !== 3'd4) begin
            errors++;
            $display("FAIL jitter bit_count got %0d exp 4", a.bit_count);
        end
    endtask

    task automatic test_rcving_drop();
        logic low, e, exp_se;
        start_a();
        for (int k = 0; k < 106; k++) begin
            low = k >= 38 && k <= 41;
            e = (k <= 32 && k % 8 == 0) || (low && k % 2 == 0) || (k >= 43 && k <= 99 && (k - 43) % 8 == 0);
            win(e, !low, 0);
            exp_se = (k <= 36 && k % 8 == 4) || (k >= 47 && (k - 47) % 8 == 0);
            checks += 2;
            if (a.shift_enable !== exp_se) begin
                errors++;
                $display("FAIL drop shift_enable k=%0d got %b exp %b", k, a.shift_enable, exp_se);
            end
            if (a.byte_received !== (k == 104)) begin
                errors++;
                $display("FAIL drop byte_received k=%0d got %b exp %b", k, a.byte_received, k == 104);
            end
            if (k >= 38 && k <= 42) begin
                checks++;
                if (a.bit_count !== (k == 38 ? 3'd5 : 3'd0)) begin
                    errors++;
                    $display("FAIL drop bit_count k=%0d got %0d exp %0d", k, a.bit_count, k == 38 ? 5 : 0);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        start_a();
        for (int k = 0; k <= 20; k++) win(k % 8 == 0 && k <= 16, 1, 0);
        checks++;
        if ({a.shift_enable, a.bit_count} !== 4'b1_010) begin
            errors++;
            $display("FAIL mid_pre se/bc got %b exp 1010", {a.shift_enable, a.bit_count});
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if ({a.shift_enable, a.byte_received, a.bit_count} !== 5'd0) begin
            errors++;
            $display("FAIL mid_reset se/br/bc got %b exp 00000", {a.shift_enable, a.byte_received, a.bit_count});
        end
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        for (int k = 1; k < 64; k++) begin
            win(k % 8 == 1 && k <= 57, 1, 0);
            checks += 2;
            if (a.shift_enable !== (k % 8 == 5)) begin
                errors++;
                $display("FAIL mid shift_enable k=%0d got %b exp %b", k, a.shift_enable, k % 8 == 5);
            end
            if (a.byte_received !== (k == 62)) begin
                errors++;
                $display("FAIL mid byte_received k=%0d got %b exp %b", k, a.byte_received, k == 62);
            end
        end
    endtask

    task automatic test_params();
        win(0, 0, 0);
        b.rcving = 1'b0;
        @(negedge clk);
        b.rcving = 1'b1;
        for (int k = 0; k < 41; k++) begin
            @(negedge clk);
            #1;
            checks += 2;
            if (b.shift_enable !== (k % 4 == 1)) begin
                errors++;
                $display("FAIL params shift_enable k=%0d got %b exp %b", k, b.shift_enable, k % 4 == 1);
            end
            if (b.byte_received !== (k == 18 || k == 38)) begin
                errors++;
                $display("FAIL params byte_received k=%0d got %b exp %b", k, b.byte_received, k == 18 || k == 38);
            end
            if (k == 17 || k == 18) begin
                checks++;
                if (b.bit_count !== (k == 17 ? 3'd4 : 3'd0)) begin
                    errors++;
                    $display("FAIL params bit_count k=%0d got %0d exp %0d", k, b.bit_count, k == 17 ? 4 : 0);
                end
            end
        end
        b.rcving = 1'b0;
    endtask

    task automatic test_stuff();
        logic stuff_on, exp_se, exp_err;
        logic [2:0] exp_bc;
`ifdef RX_BIT_STUFF_EN
        stuff_on = 1'b1;
        exp_bc = 3'd7;
`else
        stuff_on = 1'b0;
        exp_bc = 3'd0;
`endif
        for (int sv = 0; sv < 2; sv++) begin
            start_a();
            for (int k = 0; k < 64; k++) begin
                win(k % 8 == 0 && k <= 56, 1, k < 48 ? 1'b1 : (k < 56 ? sv[0] : 1'b0));
                exp_se = k % 8 == 4 && !(stuff_on && k == 52);
                exp_err = stuff_on && sv == 1 && k == 53;
                checks += 2;
                if (a.shift_enable !== exp_se) begin
                    errors++;
                    $display("FAIL stuff%0d shift_enable k=%0d got %b exp %b", sv, k, a.shift_enable, exp_se);
                end
                if (a.stuff_err !== exp_err) begin
                    errors++;
                    $display("FAIL stuff%0d stuff_err k=%0d got %b exp %b", sv, k, a.stuff_err, exp_err);
                end
            end
            checks++;
            if (a.bit_count !== exp_bc) begin
                errors++;
                $display("FAIL stuff%0d bit_count got %0d exp %0d", sv, a.bit_count, exp_bc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_edges();
        test_jitter();
        test_rcving_drop();
        test_reset_mid();
        test_params();
        test_stuff();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rx_bit_timer.md
Name: rx_bit_timer

Overview:
- Parametrised bit/byte timing generator for the USB receiver datapath.
- Recovers bit phase from data edges and emits a one-cycle shift_enable at a programmable sample point within each bit period.
- Counts sampled bits and pulses byte_received after every BITS_PER_BYTE bits.
- Sits between the edge detector and the shift register / receive FSM. Adds configurable oversampling, sample point, byte width and optional bit-stuff removal.

Parameters:
- CLKS_PER_BIT, 8: clocks per bit period; must be >= 2.
- SAMPLE_PT, 3: phase value at which the bit is sampled; must be < CLKS_PER_BIT.
- BITS_PER_BYTE, 8: data bits per byte; must be >= 2.

Ports:
- clk, input, 1: system clock, rising edge.
- n_rst, input, 1: asynchronous active-low reset.
- d_edge, input, 1: one-cycle pulse on any line transition; resynchronises bit phase.
- rcving, input, 1: high while a packet is being received; low clears all timing state.
- d_orig, input, 1: decoded bit value, valid in the shift_enable cycle. Used only with RX_BIT_STUFF_EN.
- shift_enable, output, 1: one-cycle pulse at each bit sample point.
- byte_received, output, 1: registered one-cycle pulse after the last bit of a byte.
- bit_count, output, $clog2(BITS_PER_BYTE), bits sampled so far in the current byte.
- stuff_err, output, 1: one-cycle pulse on a bit-stuff violation. Tied 0 without RX_BIT_STUFF_EN.

Behaviour:
- Reset (n_rst low, asynchronous): FSM=IDLE, phase=0, bit_count=0, ones=0. byte_received, stuff_err and shift_enable are all 0.
- FSM states:
  - IDLE: rcving low.
  - ACTIVE: normal sampling.
  - STUFF: the next sample is a stuff bit; exists only with RX_BIT_STUFF_EN.
- FSM transitions:
  - IDLE->ACTIVE when rcving=1.
  - Any state->IDLE when rcving=0. This is a synchronous clear of phase, bit_count and ones; no pulses occur in that cycle.
- Phase counter (width $clog2(CLKS_PER_BIT)), updated when not in IDLE:
  - d_edge=1 -> phase<=0.
  - Else phase==CLKS_PER_BIT-1 -> phase<=0.
  - Else phase<=phase+1.
- shift_enable: combinational, equal to (state==ACTIVE && phase==SAMPLE_PT). After an edge in cycle t, the first shift_enable is in cycle t+1+SAMPLE_PT. Free-running with no edges, the period is exactly CLKS_PER_BIT.
- d_edge in the same cycle as phase==SAMPLE_PT: shift_enable still asserts in that cycle, and phase resets to 0 next cycle.
- Bit counter, on shift_enable:
  - bit_count==BITS_PER_BYTE-1 -> bit_count<=0 and byte_received<=1 in the next cycle.
  - Else bit_count<=bit_count+1.
- byte_received is high for exactly one cycle per byte. It is never asserted in a cycle where rcving was low in the previous cycle.
- rcving falls mid-byte: the partial byte is discarded with no byte_received, and bit_count restarts at 0 on the next rcving.
- rcving held low with d_edge toggling: no outputs change.

Optional Feature:
- RX_BIT_STUFF_EN defined:
  - ones counter (3 bits) samples d_orig on every shift_enable: 1 -> ones+1, 0 -> ones<=0.
  - When ones reaches 6, FSM ACTIVE->STUFF.
  - In STUFF at phase==SAMPLE_PT: shift_enable stays 0 and bit_count does not advance. ones<=0 and FSM returns to ACTIVE.
  - If d_orig==1 at that STUFF sample, stuff_err pulses for one cycle in the next cycle.
- RX_BIT_STUFF_EN undefined:
  - STUFF state and ones counter are absent.
  - d_orig is ignored and stuff_err is constant 0.

Decomposition:
- Shared package rx_timer_pkg holds:
  - state enum (IDLE, ACTIVE, STUFF);
  - localparam STUFF_LIMIT=6;
  - width helper functions for $clog2 of the phase and bit widths.
- Sub-module rx_phase_gen: phase counter plus edge resync, parametrised by CLKS_PER_BIT and SAMPLE_PT, outputting phase and a sample_pt strobe.
- Bit counting and FSM stay in rx_bit_timer.

Test Plan:
- Defaults, rcving=1, d_edge pulses at cycles 0,8,...,56 -> shift_enable at cycles 4,12,...,60; byte_received high only at cycle 61; bit_count returns to 0.
- CLKS_PER_BIT=4, SAMPLE_PT=1, BITS_PER_BYTE=5, no edges after start -> shift_enable every 4 cycles; byte_received once every 20 cycles.
- Edge arriving 2 cycles late (jitter) -> next shift_enable 2 cycles later, with no missed or duplicated pulse.
- rcving dropped after 5 shift_enables, then restarted -> no byte_received; bit_count is 0 on restart; a full byte then completes normally.
- n_rst asserted mid-byte at phase 3 -> all outputs 0 immediately; after release, the next byte needs a full 8 bits.
- RX_BIT_STUFF_EN: d_orig=1 for 6 samples, then stuff sample d_orig=0 -> that sample's shift_enable is suppressed and stuff_err stays 0. Repeat with stuff sample d_orig=1 -> stuff_err pulses once.
